// File: rtl/lbm_pull_gather.sv
// lbm_pull_gather
//   Pull-side gather unit for a D2Q9 lattice. Raster-scans every node, issues
//   nine single-population reads per node (one per direction) and assembles
//   f_i(x) = f_i(x - c_i) into one packed vector for the collision stage.
//   Sources that fall off the lattice are replaced by half-way bounce-back:
//   the node's own address is read in the opposite direction.
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, busy, done   sweep control / status
//   rd_en, rd_addr,
//   rd_dir, rd_data     population RAM read port (data 1 cycle after rd_en)
//   out_valid,
//   out_ready           node vector handshake
//   out_pops            f0 in the top slot ... f8 in the bottom slot
//   out_addr, out_x,
//   out_y, out_bb       node address, coordinates, bounce-back mask
module lbm_pull_gather #(
    parameter int GRID_DIM      = 256,
    parameter int SIDE_LENGTH   = GRID_DIM / 16,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM) + 1,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [3:0]              rd_dir,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [9*DATA_WIDTH-1:0] out_pops,
    output logic [ADDRESS_WIDTH-1:0] out_addr,
    output logic [ADDRESS_WIDTH-1:0] out_x,
    output logic [ADDRESS_WIDTH-1:0] out_y,
    output logic [8:0]              out_bb
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_COORD = ADDRESS_WIDTH'(SIDE_LENGTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_OUT, S_DONE} state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [3:0]               dir;
        logic                     bb;
    } rd_req_t;

    // Row-flipped node map shared with the streaming unit.
    function automatic logic [ADDRESS_WIDTH-1:0] node_addr(input logic [ADDRESS_WIDTH-1:0] nx,
                                                           input logic [ADDRESS_WIDTH-1:0] ny);
        return ADDRESS_WIDTH'(GRID_DIM - SIDE_LENGTH * (1 + int'(ny)) + int'(nx));
    endfunction

    function automatic rd_req_t gen_read(input logic [ADDRESS_WIDTH-1:0] gx,
                                         input logic [ADDRESS_WIDTH-1:0] gy,
                                         input logic [3:0]               d);
        int         cx, cy, sx, sy;
        logic [3:0] opp;
        rd_req_t    r;
        cx  = 0;
        cy  = 0;
        opp = d;
        case (d)
            4'd1: begin cx =  1;          opp = 4'd3; end
            4'd2: begin          cy =  1; opp = 4'd4; end
            4'd3: begin cx = -1;          opp = 4'd1; end
            4'd4: begin          cy = -1; opp = 4'd2; end
            4'd5: begin cx =  1; cy =  1; opp = 4'd7; end
            4'd6: begin cx = -1; cy =  1; opp = 4'd8; end
            4'd7: begin cx = -1; cy = -1; opp = 4'd5; end
            4'd8: begin cx =  1; cy = -1; opp = 4'd6; end
            default: ;
        endcase
        sx = int'(gx) - cx;
        sy = int'(gy) - cy;
        if (sx < 0 || sx >= SIDE_LENGTH || sy < 0 || sy >= SIDE_LENGTH) begin
            r.addr = node_addr(gx, gy);
            r.dir  = opp;
            r.bb   = 1'b1;
        end else begin
            r.addr = ADDRESS_WIDTH'(GRID_DIM - SIDE_LENGTH * (1 + sy) + sx);
            r.dir  = d;
            r.bb   = 1'b0;
        end
        return r;
    endfunction

    state_t                  state;
    logic [3:0]              k;
    logic [DATA_WIDTH-1:0]   slot [9];

    logic [ADDRESS_WIDTH-1:0] req_x, req_y;
    logic [3:0]               req_k;
    logic                     last_node;
    rd_req_t                  req;

    // The read to be registered next: direction k+1 of the current node while
    // issuing, or direction 0 of the first/next node when a node is launched.
    always_comb begin
        req_x = out_x;
        req_y = out_y;
        req_k = k + 4'd1;
        if (state == S_IDLE) begin
            req_x = '0;
            req_y = '0;
            req_k = '0;
        end else if (state == S_OUT) begin
            req_k = '0;
            if (out_x == LAST_COORD) begin
                req_x = '0;
                req_y = out_y + 1'b1;
            end else begin
                req_x = out_x + 1'b1;
            end
        end
        req = gen_read(req_x, req_y, req_k);
    end

    assign last_node = (out_x == LAST_COORD) && (out_y == LAST_COORD);

    always_comb begin
        out_pops = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            out_pops[(8 - i) * DATA_WIDTH +: DATA_WIDTH] = slot[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k         <= '0;
            slot      <= '{default: '0};
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            rd_dir    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_bb    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ISSUE;
                        busy     <= 1'b1;
                        k        <= '0;
                        out_x    <= req_x;
                        out_y    <= req_y;
                        out_addr <= node_addr(req_x, req_y);
                        out_bb   <= {8'b0, req.bb};
                        rd_en    <= 1'b1;
                        rd_addr  <= req.addr;
                        rd_dir   <= req.dir;
                    end
                end
                S_ISSUE: begin
                    // rd_data now answers the read issued last cycle (k-1).
                    if (k != 4'd0) begin
                        slot[k - 4'd1] <= rd_data;
                    end
                    if (k == 4'd8) begin
                        rd_en <= 1'b0;
                        state <= S_CAPTURE;
                    end else begin
                        k             <= req_k;
                        rd_addr       <= req.addr;
                        rd_dir        <= req.dir;
                        out_bb[req_k] <= req.bb;
                    end
                end
                S_CAPTURE: begin
                    slot[8]   <= rd_data;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_node) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_ISSUE;
                            k        <= '0;
                            out_x    <= req_x;
                            out_y    <= req_y;
                            out_addr <= node_addr(req_x, req_y);
                            out_bb   <= {8'b0, req.bb};
                            rd_en    <= 1'b1;
                            rd_addr  <= req.addr;
                            rd_dir   <= req.dir;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbm_pull_gather.sv
module tb_lbm_pull_gather;

    localparam int DW = 16;
    localparam int AW = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   rd_data = '0;
    logic            busy, done, rd_en, out_valid;
    logic [AW-1:0]   rd_addr, out_addr, out_x, out_y;
    logic [3:0]      rd_dir;
    logic [9*DW-1:0] out_pops;
    logic [8:0]      out_bb;

    lbm_pull_gather #(
        .GRID_DIM(256),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_dir(rd_dir), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pops(out_pops),
        .out_addr(out_addr), .out_x(out_x), .out_y(out_y), .out_bb(out_bb)
    );

    always #5 clk = ~clk;

    // Population RAM stand-in: returns {dir, 3'b000, addr} one cycle after rd_en.
    always @(posedge clk) if (rd_en) rd_data <= {rd_dir, 3'b000, rd_addr};

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] w(input int d, input int a);
        return {4'(d), 3'b000, 9'(a)};
    endfunction

    function automatic logic [15:0] slot(input logic [143:0] v, input int k);
        return v[(8 - k) * 16 +: 16];
    endfunction

    // Handshake monitor
    int hs_cnt = 0, done_cnt = 0, ex = 0, ey = 0;
    bit mon_on = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (out_valid) check("rd_en_in_out", rd_en, 0);
            if (out_valid && out_ready) begin
                check("node_x", out_x, ex);
                check("node_y", out_y, ey);
                check("node_addr", out_addr, 256 - 16 * (1 + ey) + ex);
                if (ex == 5 && ey == 5) begin
                    check("n55_d0", slot(out_pops, 0), w(0, 165));
                    check("n55_d1", slot(out_pops, 1), w(1, 164));
                    check("n55_d2", slot(out_pops, 2), w(2, 181));
                    check("n55_d5", slot(out_pops, 5), w(5, 180));
                    check("n55_bb", out_bb, 0);
                    check("n55_addr", out_addr, 165);
                end
                if (ex == 15 && ey == 15) begin
                    check("n1515_addr", out_addr, 15);
                    check("n1515_bb", out_bb, 9'h1D8);
                    check("n1515_d1", slot(out_pops, 1), w(1, 14));
                end
                hs_cnt++;
                if (ex == 15) begin ex = 0; ey++; end else ex++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        check(tag, out_valid, 1);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 4000) begin @(negedge clk); t++; end
        check(tag, done, 1);
    endtask

    logic [143:0] exp0;

    initial begin
        exp0 = {w(0,240), w(3,240), w(4,240), w(3,241), w(4,224),
                w(7,240), w(8,240), w(7,225), w(6,240)};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_pops", out_pops, 0);
        check("rst_bb", out_bb, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Sweep with a stalled first node
        mon_on = 1;
        pulse_start();
        check("busy_after_start", busy, 1);
        check("first_rd_en", rd_en, 1);
        check("first_rd_addr", rd_addr, 240);
        check("first_rd_dir", rd_dir, 0);
        wait_valid("node0_valid");
        check("node0_pops", out_pops, exp0);
        check("node0_bb", out_bb, 9'h166);
        check("node0_addr", out_addr, 240);
        repeat (20) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_pops", out_pops, exp0);
            check("stall_bb", out_bb, 9'h166);
            check("stall_rd_en", rd_en, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_rd_en", rd_en, 1);
        check("release_rd_addr", rd_addr, 241);
        check("release_rd_dir", rd_dir, 0);

        // Stray start pulses while busy
        repeat (100) @(posedge clk);
        pulse_start();
        repeat (537) @(posedge clk);
        pulse_start();
        wait_done("sweep_done");
        check("busy_at_done", busy, 0);
        start = 1'b1;                      // coincides with the done cycle
        @(posedge clk); #1 start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_rd_en", rd_en, 0);
        end
        check("handshakes", hs_cnt, 256);
        check("done_pulses", done_cnt, 1);

        // Reset in the middle of node 37
        hs_cnt = 0; ex = 0; ey = 0; done_cnt = 0;
        pulse_start();
        begin
            int t = 0;
            do begin @(negedge clk); #1; t++; end
            while (!(hs_cnt == 37 && rd_en) && t < 1000);
        end
        check("reached_node37", hs_cnt, 37);
        rst_n = 1'b0;
        mon_on = 0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_rd_en", rd_en, 0);
        check("arst_rd_addr", rd_addr, 0);
        check("arst_rd_dir", rd_dir, 0);
        check("arst_valid", out_valid, 0);
        check("arst_pops", out_pops, 0);
        check("arst_addr", out_addr, 0);
        check("arst_x", out_x, 0);
        check("arst_y", out_y, 0);
        check("arst_bb", out_bb, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        hs_cnt = 0; ex = 0; ey = 0; done_cnt = 0;
        mon_on = 1;
        pulse_start();
        wait_valid("resweep_valid");
        check("resweep_x", out_x, 0);
        check("resweep_y", out_y, 0);
        check("resweep_addr", out_addr, 240);
        check("resweep_bb", out_bb, 9'h166);
        wait_done("resweep_done");
        repeat (2) @(negedge clk);
        check("resweep_handshakes", hs_cnt, 256);
        check("resweep_done_pulses", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
